// File: rtl/tbus_pkg.sv
// Shared tbus definitions: op types, arbiter state and requester ids.
package tbus_pkg;
  localparam int OPTYPE_W = 2;
  localparam logic [OPTYPE_W-1:0] TBUS_READ  = 2'b00;
  localparam logic [OPTYPE_W-1:0] TBUS_WRITE = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_BUSY  = 2'd2,
    S_DRAIN = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_LD = 1'b0,
    REQ_ST = 1'b1
  } req_id_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. Bit 0 is the load unit, bit 1 the store drain.
// On a tie the requester that was not served last wins.
module rr_arb2
  import tbus_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    last,
  output logic [1:0] grant
);

  // Single requester passes through; a tie goes to the one not served last.
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = (last == REQ_ST) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/dcache_tbus_arb.sv
// Arbiter/sequencer for the single tbus port into the dcache. Load unit and
// store drain share it; one transaction at a time, ownership held from
// request to dc_done. Load flushes withdraw a pending load or swallow the
// response of an accepted one.
module dcache_tbus_arb
  import tbus_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int OPTYPE_W = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ld_req_valid,
  output logic                ld_req_ready,
  input  logic [ADDR_W-1:0]   ld_req_index,
  input  logic [OPTYPE_W-1:0] ld_req_optype,
  input  logic                ld_flush_valid,
  output logic [DATA_W-1:0]   ld_resp_data,
  output logic                ld_resp_done,
  input  logic                st_req_valid,
  output logic                st_req_ready,
  input  logic [ADDR_W-1:0]   st_req_index,
  input  logic [DATA_W-1:0]   st_req_wdata,
  input  logic [DATA_W-1:0]   st_req_wmask,
  input  logic [OPTYPE_W-1:0] st_req_optype,
  output logic                st_resp_done,
  output logic                dc_index_valid,
  input  logic                dc_index_ready,
  output logic [ADDR_W-1:0]   dc_index,
  output logic [DATA_W-1:0]   dc_write_data,
  output logic [DATA_W-1:0]   dc_write_mask,
  output logic [OPTYPE_W-1:0] dc_optype,
  input  logic [DATA_W-1:0]   dc_read_data,
  input  logic                dc_done
);

  arb_state_e state;
  req_id_e    owner;
  req_id_e    rr_last;

  logic [1:0] cand;
  logic [1:0] grant;
  logic       sel_v;
  req_id_e    sel_id;
  logic       fire;
  logic       ld_busy;
  logic       ld_kill;

  // A flushing load is not a candidate for a new grant.
  assign cand    = {st_req_valid, ld_req_valid & ~ld_flush_valid};
  assign ld_kill = (owner == REQ_LD) & ld_flush_valid;

  rr_arb2 u_rr (
    .req   (cand),
    .last  (rr_last),
    .grant (grant)
  );

  // Who drives the tbus request this cycle: new winner in IDLE, owner in REQ.
  always_comb begin
    sel_v  = 1'b0;
    sel_id = REQ_LD;
    case (state)
      S_IDLE: begin
        sel_v  = |grant;
        sel_id = grant[1] ? REQ_ST : REQ_LD;
      end
      S_REQ: begin
        sel_v  = ~ld_kill;
        sel_id = owner;
      end
      default: ;
    endcase
  end

  assign fire    = sel_v & dc_index_ready;
  assign ld_busy = (state == S_BUSY) & (owner == REQ_LD);

  // Request payload mux; payloads read zero whenever no request is offered.
  // Everything is gated by reset_n so outputs drop the moment reset asserts.
  always_comb begin
    dc_index_valid = sel_v & reset_n;
    dc_index       = '0;
    dc_write_data  = '0;
    dc_write_mask  = '0;
    dc_optype      = '0;
    if (sel_v && reset_n) begin
      if (sel_id == REQ_ST) begin
        dc_index      = st_req_index;
        dc_write_data = st_req_wdata;
        dc_write_mask = st_req_wmask;
        dc_optype     = st_req_optype;
      end else begin
        dc_index  = ld_req_index;
        dc_optype = ld_req_optype;
      end
    end
  end

  // Handshake and response demux back to the owner only.
  always_comb begin
    ld_req_ready = fire & (sel_id == REQ_LD) & reset_n;
    st_req_ready = fire & (sel_id == REQ_ST) & reset_n;
    ld_resp_done = ld_busy & dc_done & ~ld_flush_valid & reset_n;
    st_resp_done = (state == S_BUSY) & (owner == REQ_ST) & dc_done & reset_n;
    ld_resp_data = (ld_busy && reset_n) ? dc_read_data : '0;
  end

  // Ownership FSM; rr_last only moves when a transaction completes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      owner   <= REQ_LD;
      rr_last <= REQ_ST;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_v) begin
            owner <= sel_id;
            state <= fire ? S_BUSY : S_REQ;
          end
        end
        S_REQ: begin
          if (ld_kill)   state <= S_IDLE;
          else if (fire) state <= S_BUSY;
        end
        S_BUSY: begin
          if (dc_done) begin
            state   <= S_IDLE;
            rr_last <= owner;
          end else if (ld_kill) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (dc_done) begin
            state   <= S_IDLE;
            rr_last <= REQ_LD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_tbus_arb.sv
// Bench for dcache_tbus_arb: directed vector table for the multi-cycle
// corner cases, then randomized traffic against a transaction-level model.
module tb_dcache_tbus_arb;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int OW = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          ld_req_valid, ld_req_ready, ld_flush_valid, ld_resp_done;
  logic [AW-1:0] ld_req_index;
  logic [OW-1:0] ld_req_optype;
  logic [DW-1:0] ld_resp_data;
  logic          st_req_valid, st_req_ready, st_resp_done;
  logic [AW-1:0] st_req_index;
  logic [DW-1:0] st_req_wdata, st_req_wmask;
  logic [OW-1:0] st_req_optype;
  logic          dc_index_valid, dc_index_ready, dc_done;
  logic [AW-1:0] dc_index;
  logic [DW-1:0] dc_write_data, dc_write_mask, dc_read_data;
  logic [OW-1:0] dc_optype;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  dcache_tbus_arb #(.ADDR_W(AW), .DATA_W(DW), .OPTYPE_W(OW)) dut (
    .clock(clock), .reset_n(reset_n),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
    .ld_req_index(ld_req_index), .ld_req_optype(ld_req_optype),
    .ld_flush_valid(ld_flush_valid), .ld_resp_data(ld_resp_data),
    .ld_resp_done(ld_resp_done),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
    .st_req_index(st_req_index), .st_req_wdata(st_req_wdata),
    .st_req_wmask(st_req_wmask), .st_req_optype(st_req_optype),
    .st_resp_done(st_resp_done),
    .dc_index_valid(dc_index_valid), .dc_index_ready(dc_index_ready),
    .dc_index(dc_index), .dc_write_data(dc_write_data),
    .dc_write_mask(dc_write_mask), .dc_optype(dc_optype),
    .dc_read_data(dc_read_data), .dc_done(dc_done)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ctl = {dc_index_valid, ld_req_ready, st_req_ready, ld_resp_done, st_resp_done}
  typedef struct {
    logic          rst, ld, fl, st, rdy, dn;
    logic [63:0]   rdata;
    logic [4:0]    ctl;
    logic [63:0]   idx, wd, wm, rd;
  } vec_t;

  vec_t tbl[$];

  localparam logic [63:0] LI = 64'h8000_1000;
  localparam logic [63:0] SI = 64'h8000_2000;

  function automatic vec_t mk(logic rst, logic ld, logic fl, logic st, logic rdy,
                              logic dn, logic [63:0] rdata, logic [4:0] ctl,
                              logic [63:0] idx, logic [63:0] rd);
    vec_t v;
    v.rst = rst; v.ld = ld; v.fl = fl; v.st = st; v.rdy = rdy; v.dn = dn;
    v.rdata = rdata; v.ctl = ctl; v.idx = idx; v.rd = rd;
    v.wd = (ctl[4] && idx == SI) ? 64'h55 : 64'h0;
    v.wm = (ctl[4] && idx == SI) ? 64'hFF : 64'h0;
    return v;
  endfunction

  // Transaction-level reference state for the random phase.
  int   m_own;     // -1 none, 0 load, 1 store
  bit   m_acc;     // owner's request accepted by dcache
  bit   m_cancel;  // accepted load flushed, response to be dropped
  bit   m_last;    // 1 = store was served last

  initial begin
    reset_n = 1'b0;
    ld_req_valid = 0; ld_flush_valid = 0; st_req_valid = 0;
    dc_index_ready = 0; dc_done = 0; dc_read_data = '0;
    ld_req_index = LI; ld_req_optype = 2'b00;
    st_req_index = SI; st_req_wdata = 64'h55; st_req_wmask = 64'hFF;
    st_req_optype = 2'b01;

    // load only, done 3 cycles after fire
    tbl.push_back(mk(0,1,0,0,1,0,0,            5'b11000, LI, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,            5'b00000, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,            5'b00000, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,1,64'hDEADBEEF, 5'b00010, 0, 64'hDEADBEEF));
    // reset, then both valid: load first, store after
    tbl.push_back(mk(1,1,0,1,1,0,0,            5'b00000, 0, 0));
    tbl.push_back(mk(0,1,0,1,1,0,0,            5'b11000, LI, 0));
    tbl.push_back(mk(0,0,0,1,1,0,0,            5'b00000, 0, 0));
    tbl.push_back(mk(0,0,0,1,0,1,64'h1234,     5'b00010, 0, 64'h1234));
    tbl.push_back(mk(0,0,0,1,1,0,0,            5'b10100, SI, 0));
    tbl.push_back(mk(0,0,0,0,0,1,64'h99,       5'b00001, 0, 0));
    // store held in REQ four cycles, load waiting
    tbl.push_back(mk(0,0,0,1,0,0,0,            5'b10000, SI, 0));
    tbl.push_back(mk(0,1,0,1,0,0,0,            5'b10000, SI, 0));
    tbl.push_back(mk(0,1,0,1,0,0,0,            5'b10000, SI, 0));
    tbl.push_back(mk(0,1,0,1,0,0,0,            5'b10000, SI, 0));
    tbl.push_back(mk(0,1,0,1,1,0,0,            5'b10100, SI, 0));
    tbl.push_back(mk(0,1,0,0,0,1,64'h5,        5'b00001, 0, 0));
    // load accepted, flushed before done: drain, no grant until done
    tbl.push_back(mk(0,1,0,0,1,0,0,            5'b11000, LI, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,            5'b00000, 0, 0));
    tbl.push_back(mk(0,0,1,0,0,0,0,            5'b00000, 0, 0));
    tbl.push_back(mk(0,0,0,1,1,0,0,            5'b00000, 0, 0));
    tbl.push_back(mk(0,0,0,1,1,1,64'hAA,       5'b00000, 0, 0));
    tbl.push_back(mk(0,0,0,1,1,0,0,            5'b10100, SI, 0));
    tbl.push_back(mk(0,0,0,0,0,1,0,            5'b00001, 0, 0));
    // load in REQ withdrawn by flush, pending store granted next
    tbl.push_back(mk(0,1,0,0,0,0,0,            5'b10000, LI, 0));
    tbl.push_back(mk(0,1,1,1,1,0,0,            5'b00000, 0, 0));
    tbl.push_back(mk(0,0,0,1,1,0,0,            5'b10100, SI, 0));
    tbl.push_back(mk(0,0,0,0,0,1,0,            5'b00001, 0, 0));
    // flush coincident with done, then reset mid-BUSY
    tbl.push_back(mk(0,1,0,0,1,0,0,            5'b11000, LI, 0));
    tbl.push_back(mk(0,0,1,0,0,1,64'h77,       5'b00000, 0, 64'h77));
    tbl.push_back(mk(0,1,0,0,1,0,0,            5'b11000, LI, 0));
    tbl.push_back(mk(1,1,0,0,1,1,64'h33,       5'b00000, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,1,64'h44,       5'b00000, 0, 0));

    @(negedge clock);
    #1;
    chk("reset_ctl", {251'd0, dc_index_valid, ld_req_ready, st_req_ready,
                      ld_resp_done, st_resp_done}, 256'd0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clock);
      reset_n        = ~tbl[i].rst;
      ld_req_valid   = tbl[i].ld;
      ld_flush_valid = tbl[i].fl;
      st_req_valid   = tbl[i].st;
      dc_index_ready = tbl[i].rdy;
      dc_done        = tbl[i].dn;
      dc_read_data   = tbl[i].rdata;
      #1;
      chk($sformatf("vec%0d_ctl", i),
          {251'd0, dc_index_valid, ld_req_ready, st_req_ready, ld_resp_done, st_resp_done},
          {251'd0, tbl[i].ctl});
      chk($sformatf("vec%0d_payload", i),
          {64'd0, dc_index, dc_write_data, dc_write_mask},
          {64'd0, tbl[i].idx, tbl[i].wd, tbl[i].wm});
      chk($sformatf("vec%0d_lddata", i), {192'd0, ld_resp_data}, {192'd0, tbl[i].rd});
    end

    // Random phase: fresh reset so the model starts from a known state.
    @(negedge clock);
    reset_n = 1'b0;
    ld_req_valid = 0; st_req_valid = 0; ld_flush_valid = 0;
    dc_index_ready = 0; dc_done = 0;
    @(negedge clock);
    reset_n = 1'b1;
    m_own = -1; m_acc = 0; m_cancel = 0; m_last = 1;
    begin
      bit ldp = 0, stp = 0, out = 0;
      int cnt = 0;
      for (int c = 0; c < 600; c++) begin
        int win;
        logic [4:0] e_ctl;
        logic [63:0] e_idx, e_wd, e_wm;
        logic [1:0]  e_op;
        bit cl, fire_obs;
        @(negedge clock);
        if (!ldp && $urandom_range(0, 2) == 0) begin
          ldp = 1; ld_req_index = {$urandom, $urandom};
        end
        if (!stp && $urandom_range(0, 2) == 0) begin
          stp = 1; st_req_index = {$urandom, $urandom};
          st_req_wdata = {$urandom, $urandom}; st_req_wmask = {$urandom, $urandom};
        end
        ld_req_valid   = ldp;
        st_req_valid   = stp;
        ld_flush_valid = ($urandom_range(0, 9) == 0);
        dc_index_ready = $urandom_range(0, 1);
        dc_done        = out && cnt == 1;
        dc_read_data   = {$urandom, $urandom};
        #1;
        // expected outputs from the model
        win = -1;
        e_ctl = '0; e_idx = '0; e_wd = '0; e_wm = '0; e_op = '0;
        if (m_own < 0) begin
          cl = ld_req_valid && !ld_flush_valid;
          if (cl && st_req_valid) win = m_last ? 0 : 1;
          else if (cl)            win = 0;
          else if (st_req_valid)  win = 1;
        end else if (!m_acc) begin
          if (!(m_own == 0 && ld_flush_valid)) win = m_own;
        end
        if (win == 0) begin
          e_ctl[4] = 1; e_ctl[3] = dc_index_ready;
          e_idx = ld_req_index; e_op = 2'b00;
        end else if (win == 1) begin
          e_ctl[4] = 1; e_ctl[2] = dc_index_ready;
          e_idx = st_req_index; e_wd = st_req_wdata; e_wm = st_req_wmask; e_op = 2'b01;
        end
        if (m_own >= 0 && m_acc && dc_done) begin
          if (m_own == 0 && !m_cancel && !ld_flush_valid) e_ctl[1] = 1;
          if (m_own == 1) e_ctl[0] = 1;
        end
        chk($sformatf("rnd%0d", c),
            {57'd0, dc_optype, dc_index_valid, ld_req_ready, st_req_ready,
             ld_resp_done, st_resp_done, dc_index, dc_write_data, dc_write_mask},
            {57'd0, e_op, e_ctl, e_idx, e_wd, e_wm});
        if (e_ctl[1]) chk($sformatf("rnd%0d_lddata", c), {192'd0, ld_resp_data},
                          {192'd0, dc_read_data});
        // advance model
        if (win >= 0) begin
          m_own = win; m_acc = dc_index_ready; m_cancel = 0;
        end else if (m_own == 0 && !m_acc && ld_flush_valid) begin
          m_own = -1;
        end else if (m_own >= 0 && m_acc && dc_done) begin
          m_last = (m_own == 1); m_own = -1; m_acc = 0;
        end else if (m_own == 0 && m_acc && ld_flush_valid) begin
          m_cancel = 1;
        end
        // requester and dcache emulation
        fire_obs = dc_index_valid && dc_index_ready;
        if (ld_req_ready || ld_flush_valid) ldp = 0;
        if (st_req_ready) stp = 0;
        if (dc_done) out = 0;
        else if (out) cnt--;
        if (fire_obs) begin
          out = 1; cnt = $urandom_range(1, 4);
        end
        @(posedge clock);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
